stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the stopwatch BCD counter datapath (minutes / tens / ones / tenths). It converts the Start, Stop and Clear button levels into edge events and runs the IDLE/RUN/PAUSE/EXPIRED state machine. It generates the 10 Hz count-enable tick from the system clock and drives the datapath's tick, direction and clear controls. The datapath reports its terminal values back through `at_zero` and `at_max`; this block owns all start/stop/clear and terminal-count policy.

## Interface
Parameters:
- TICK_DIV, default 10_000_000. Number of clk cycles per tenth-second tick; 100 MHz gives 10 Hz. Legal range is ≥ 2.
- DIV_W, default 24. Prescaler width; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk.
- btn_start  in  1  Start button level, already synchronized/debounced.
- btn_stop  in  1  Stop button level, already synchronized/debounced.
- btn_clear  in  1  Clear button level, already synchronized/debounced.
- mode_down  in  1  1 = countdown, 0 = count up; sampled only in IDLE.
- at_zero  in  1  datapath reads 0:00.0.
- at_max  in  1  datapath reads 9:59.9.
- tick  out  1  one-cycle increment/decrement enable to the datapath.
- dir  out  1  latched direction, 1 = down.
- clr  out  1  one-cycle datapath clear pulse.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.

## Operation
- Edge detect: each button has a previous-value register. An event is `btn & ~prev`. A held button produces exactly one event.
- States are IDLE, RUN, PAUSE and EXPIRED; encoding is free.
- IDLE:
  - dir follows mode_down every cycle.
  - A start event goes to RUN, unless mode_down=1 and at_zero=1, in which case start is ignored.
  - A clear event pulses clr and the state stays IDLE.
- RUN:
  - dir is frozen.
  - The prescaler counts 0..TICK_DIV-1 and wraps; tick fires on the wrap.
  - A stop event goes to PAUSE.
  - Clear events are ignored.
  - Terminal check runs every cycle, ahead of the prescaler. If (dir=0 & at_max) or (dir=1 & at_zero), go to EXPIRED with no tick that cycle. The datapath therefore never wraps.
- PAUSE:
  - The prescaler holds its value and no ticks fire.
  - A start event returns to RUN and counting continues from the held prescaler value (no lost fraction).
  - A clear event pulses clr and goes to IDLE.
- EXPIRED:
  - The prescaler is held and no ticks fire; start and stop are ignored.
  - A clear event pulses clr and goes to IDLE.
- Simultaneous events:
  - Stop beats start in every state.
  - In PAUSE, a clear with start goes to IDLE (clear wins).
  - In RUN, a clear with stop goes to PAUSE and the clear is dropped.
- Prescaler reset: it is set to 0 on the IDLE→RUN transition and on any clear.

## Timing
- Reset values:
  - state IDLE, prescaler 0, all prev registers 0.
  - tick=0, clr=0, running=0, expired=0, dir=0.
- All outputs are registered.
- Button response:
  - A button high at clock edge n (prev=0) produces the state change and any clr pulse at edge n.
  - The new running/expired/clr values are visible in the cycle after edge n.
- Tick timing:
  - First tick is TICK_DIV cycles after running rises; after that, one tick every TICK_DIV cycles.
  - tick is high for exactly 1 cycle and only while running=1.
- Resume: after PAUSE at prescaler value p, the first tick arrives TICK_DIV-p cycles after running rises again.
- Expiry latency: EXPIRED is entered at the first edge where the terminal condition holds in RUN. expired rises 1 cycle after the datapath reaches its terminal value.
- Reset in the middle of RUN/PAUSE/EXPIRED returns to IDLE at that edge with no clr pulse; the datapath has its own reset.

## Test plan
Use TICK_DIV=4 throughout.
- Reset, then start with mode_down=0 → running=1 the next cycle; ticks at cycles 4, 8, 12 after running rises; tick is never 2 cycles wide; btn_start held for 10 cycles yields one event.
- RUN, stop at prescaler=2, wait 20 cycles, start → no ticks while paused; first tick 2 cycles after running rises again.
- Countdown: mode_down=1, at_zero=0, start; raise at_zero after 3 ticks → expired=1 the next cycle, no further ticks; clear → clr pulse for 1 cycle, state IDLE, expired=0.
- Count up with at_max forced to 1 → EXPIRED with no tick issued; start and stop ignored; clear → IDLE.
- Simultaneous events:
  - start+stop in IDLE → stays IDLE.
  - stop+clear in RUN → PAUSE, no clr.
  - start+clear in PAUSE → IDLE with clr.
  - mode_down toggled during RUN → dir unchanged.
- Start in IDLE with mode_down=1 and at_zero=1 → ignored, running stays 0. Reset asserted mid-RUN → all outputs at their reset values next cycle, clr=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns button levels into edge events, runs the
// IDLE/RUN/PAUSE/EXPIRED machine and drives the BCD datapath's tick, dir and clr.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10_000_000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_clear,
  input  logic mode_down,
  input  logic at_zero,
  input  logic at_max,
  output logic tick,
  output logic dir,
  output logic clr,
  output logic running,
  output logic expired
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  localparam logic [DIV_W-1:0] PrescLast = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             start_prev_q, stop_prev_q, clear_prev_q;
  logic             start_ev, stop_ev, clear_ev;
  logic             tick_q, tick_d;
  logic             clr_q, clr_d;
  logic             dir_q, dir_d;
  logic             running_q, expired_q;
  logic             terminal;

  assign start_ev = btn_start & ~start_prev_q;
  assign stop_ev  = btn_stop & ~stop_prev_q;
  assign clear_ev = btn_clear & ~clear_prev_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    clr_d    = 1'b0;
    dir_d    = dir_q;
    terminal = dir_q ? at_zero : at_max;
    unique case (state_q)
      StIdle: begin
        dir_d = mode_down;
        if (clear_ev) begin
          clr_d   = 1'b1;
          presc_d = '0;
        end else if (start_ev && !stop_ev && !(mode_down && at_zero)) begin
          state_d = StRun;
          presc_d = '0;
        end
      end
      StRun: begin
        // Terminal check pre-empts the tick so the datapath never wraps.
        if (terminal) begin
          state_d = StExpired;
        end else if (stop_ev) begin
          state_d = StPause;
        end else if (presc_q == PrescLast) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      StPause: begin
        if (clear_ev) begin
          state_d = StIdle;
          clr_d   = 1'b1;
          presc_d = '0;
        end else if (start_ev && !stop_ev) begin
          state_d = StRun;
        end
      end
      StExpired: begin
        if (clear_ev) begin
          state_d = StIdle;
          clr_d   = 1'b1;
          presc_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
      tick_q       <= 1'b0;
      clr_q        <= 1'b0;
      dir_q        <= 1'b0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      start_prev_q <= btn_start;
      stop_prev_q  <= btn_stop;
      clear_prev_q <= btn_clear;
      tick_q       <= tick_d;
      clr_q        <= clr_d;
      dir_q        <= dir_d;
      running_q    <= (state_d == StRun);
      expired_q    <= (state_d == StExpired);
    end
  end

  assign tick    = tick_q;
  assign clr     = clr_q;
  assign dir     = dir_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model predicts each cycle's outputs
// into a queue, and an independent monitor pops and compares after every clock edge.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset, btn_start, btn_stop, btn_clear, mode_down, at_zero, at_max;
  logic tick, dir, clr, running, expired;

  stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_clear(btn_clear), .mode_down(mode_down), .at_zero(at_zero), .at_max(at_max),
    .tick(tick), .dir(dir), .clr(clr), .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  logic [4:0] got_v, exp_v;

  // Reference model: mode is one of "idle", "run", "pause", "expired"; elapsed counts
  // run cycles since the count was last zeroed, and a tick lands on every multiple of TD.
  string m_mode = "idle";
  int    m_elapsed = 0;
  bit    m_dir = 0;
  bit    m_ps = 0, m_pp = 0, m_pc = 0;
  bit    cur_md = 0, cur_az = 0, cur_am = 0;

  task automatic step(input bit r, input bit s, input bit p, input bit c);
    bit es, ep, ec, e_tick, e_clr, term;
    string old_mode;
    @(negedge clk);
    reset = r; btn_start = s; btn_stop = p; btn_clear = c;
    mode_down = cur_md; at_zero = cur_az; at_max = cur_am;
    e_tick = 0; e_clr = 0;
    if (r) begin
      m_mode = "idle"; m_elapsed = 0; m_dir = 0; m_ps = 0; m_pp = 0; m_pc = 0;
    end else begin
      es = s && !m_ps; ep = p && !m_pp; ec = c && !m_pc;
      m_ps = s; m_pp = p; m_pc = c;
      old_mode = m_mode;
      if (m_mode == "idle") begin
        if (ec) begin
          e_clr = 1; m_elapsed = 0;
        end else if (es && !ep && !(cur_md && cur_az)) begin
          m_mode = "run"; m_elapsed = 0;
        end
      end else if (m_mode == "run") begin
        term = m_dir ? cur_az : cur_am;
        if (term) m_mode = "expired";
        else if (ep) m_mode = "pause";
        else begin
          m_elapsed++;
          if (m_elapsed % TD == 0) e_tick = 1;
        end
      end else if (m_mode == "pause") begin
        if (ec) begin
          m_mode = "idle"; e_clr = 1; m_elapsed = 0;
        end else if (es && !ep) m_mode = "run";
      end else begin
        if (ec) begin
          m_mode = "idle"; e_clr = 1; m_elapsed = 0;
        end
      end
      if (old_mode == "idle") m_dir = cur_md;
    end
    exp_q.push_back({e_tick, e_clr, m_mode == "run", m_mode == "expired", m_dir});
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {tick, clr, running, expired, dir};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL outputs cycle %0d: got tick/clr/run/exp/dir=%b required %b",
                 cyc, got_v, exp_v);
      end
    end
  end

  initial begin
    reset = 1; btn_start = 0; btn_stop = 0; btn_clear = 0;
    mode_down = 0; at_zero = 0; at_max = 0;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    // Count up; start held 10 cycles gives a single event; ticks at 4, 8, 12.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    idle_steps(14);
    // Clear out, then pause at prescaler 2 and resume.
    step(0, 0, 1, 0); step(0, 0, 0, 1); step(0, 0, 0, 0);
    step(0, 1, 0, 0); idle_steps(2); step(0, 0, 1, 0); idle_steps(20);
    step(0, 1, 0, 0); idle_steps(6);
    step(0, 0, 1, 0); step(0, 0, 0, 1); idle_steps(2);
    // Countdown reaching zero after 3 ticks.
    cur_md = 1; idle_steps(1);
    step(0, 1, 0, 0); idle_steps(12);
    cur_az = 1; idle_steps(4);
    step(0, 0, 0, 1); idle_steps(2);
    cur_az = 0; cur_md = 0; idle_steps(1);
    // Count up with at_max already set: expires without a tick; start/stop ignored.
    cur_am = 1;
    step(0, 1, 0, 0); idle_steps(3);
    step(0, 1, 0, 0); step(0, 0, 1, 0); idle_steps(1);
    step(0, 0, 0, 1); idle_steps(1);
    cur_am = 0;
    // Simultaneous events.
    step(0, 1, 1, 0); idle_steps(2);
    step(0, 1, 0, 0); idle_steps(2); step(0, 0, 1, 1); idle_steps(2);
    step(0, 1, 0, 1); idle_steps(2);
    // mode_down toggling during RUN leaves dir alone.
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin cur_md = ~cur_md; idle_steps(1); end
    cur_md = 0; step(0, 0, 1, 0); step(0, 0, 0, 1); idle_steps(1);
    // Countdown start at zero is ignored.
    cur_md = 1; cur_az = 1; idle_steps(1); step(0, 1, 0, 0); idle_steps(3);
    cur_md = 0; cur_az = 0;
    // Reset mid-RUN.
    step(0, 1, 0, 0); idle_steps(3); step(1, 0, 0, 0); idle_steps(2);
    // Randomized traffic.
    begin
      bit s = 0, p = 0, c = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(5) == 0) s = ~s;
        if ($urandom_range(7) == 0) p = ~p;
        if ($urandom_range(9) == 0) c = ~c;
        if ($urandom_range(9) == 0) cur_md = ~cur_md;
        cur_az = ($urandom_range(19) == 0);
        cur_am = ($urandom_range(19) == 0);
        step($urandom_range(299) == 0, s, p, c);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
